// File: rtl/psum_accumulator.sv
// Sums TERMS x CHANNELS unsigned partial sums per output pixel, then shifts and saturates to DATA_WIDTH.
// Result appears the cycle after the final beat; in_ready drops while a result is held and out_ready is low.
module psum_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 2*DATA_WIDTH+2,
    parameter int TERMS      = 3,
    parameter int CHANNELS   = 4,
    parameter int ACC_WIDTH  = PSUM_WIDTH+4,
    parameter int OUT_SHIFT  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PSUM_WIDTH-1:0] in_psum,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sat,
    output logic                  busy
);

    localparam int TW = (TERMS > 1) ? $clog2(TERMS) : 1;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [ACC_WIDTH-1:0] MAX_OUT = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                state, state_nxt;
    logic [TW-1:0]         term_cnt;
    logic [CW-1:0]         ch_cnt;
    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  sum;
    logic [ACC_WIDTH-1:0]  shifted;
    logic                  accept;
    logic                  take;
    logic                  last_term;
    logic                  last_ch;
    logic                  final_beat;
    logic                  clamp;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    // clr swallows any beat arriving in the same cycle
    assign take       = accept && !clr;
    assign last_term  = (term_cnt == TW'(TERMS-1));
    assign last_ch    = (ch_cnt == CW'(CHANNELS-1));
    assign final_beat = take && last_term && last_ch;

    assign sum     = acc + {{(ACC_WIDTH-PSUM_WIDTH){1'b0}}, in_psum};
    assign shifted = sum >> OUT_SHIFT;
    assign clamp   = (shifted > MAX_OUT);
    assign busy    = (state == ACCUM);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take && !final_beat) state_nxt = ACCUM;
            ACCUM:   if (clr || final_beat)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            term_cnt <= '0;
            ch_cnt   <= '0;
        end else if (clr || final_beat) begin
            acc      <= '0;
            term_cnt <= '0;
            ch_cnt   <= '0;
        end else if (take) begin
            acc <= sum;
            if (last_term) begin
                term_cnt <= '0;
                ch_cnt   <= ch_cnt + CW'(1);
            end else begin
                term_cnt <= term_cnt + TW'(1);
            end
        end
    end

    // A new result may load in the same cycle the previous one drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (final_beat) begin
            out_valid <= 1'b1;
            out_data  <= clamp ? {DATA_WIDTH{1'b1}} : shifted[DATA_WIDTH-1:0];
            out_sat   <= clamp;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed checks of psum_accumulator: group results, saturation edge, backpressure, clr, async reset, streaming.
module tb_psum_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] in_psum = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_sat;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int xfers = 0;

    psum_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_psum   (in_psum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid && out_ready) xfers = xfers + 1;
    end

    typedef struct {
        logic [17:0] psum;
        logic [7:0]  data;
        logic        sat;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // n beats of constant p, one per cycle; mid-group beats must leave busy=1 and no result
    task automatic feed(input logic [17:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_psum  = p;
            @(posedge clk); #1;
            if (i < 11) check("mid_group_valid_busy", {30'd0, out_valid, busy}, 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [7:0] d, input logic s);
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({name, "_data"},  {24'd0, out_data},  {24'd0, d});
        check({name, "_sat"},   {31'd0, out_sat},   {31'd0, s});
        check({name, "_busy"},  {31'd0, busy},      32'd0);
    endtask

    initial begin
        int start;
        logic [23:0] vpat;
        logic        rdy_all;
        logic [7:0]  d12, d24;

        vecs[0] = '{psum: 18'd16,     data: 8'd12,  sat: 1'b0};
        vecs[1] = '{psum: 18'd195075, data: 8'd255, sat: 1'b1};
        vecs[2] = '{psum: 18'd100,    data: 8'd75,  sat: 1'b0};
        vecs[3] = '{psum: 18'd0,      data: 8'd0,   sat: 1'b0};
        vecs[4] = '{psum: 18'd341,    data: 8'd255, sat: 1'b0};
        vecs[5] = '{psum: 18'd342,    data: 8'd255, sat: 1'b1};
        vecs[6] = '{psum: 18'd1,      data: 8'd0,   sat: 1'b0};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  {24'd0, out_data},  32'd0);
        check("rst_out_sat",   {31'd0, out_sat},   32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // table-driven full groups with out_ready held high
        for (int v = 0; v < 7; v++) begin
            feed(vecs[v].psum, 12);
            check_result("vec", vecs[v].data, vecs[v].sat);
            @(posedge clk); #1;
            check("vec_drained", {31'd0, out_valid}, 32'd0);
        end

        // backpressure: A held, B offered and refused, then both proceed
        out_ready = 1'b0;
        feed(18'd16, 12);
        check_result("bp_a", 8'd12, 1'b0);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        start = xfers;
        in_valid = 1'b1;
        in_psum  = 18'd32;
        repeat (3) @(posedge clk);
        #1;
        check("bp_b_blocked_busy", {31'd0, busy},     32'd0);
        check("bp_a_held_data",    {24'd0, out_data}, 32'd12);
        check("bp_a_held_valid",   {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        feed(18'd32, 12);
        check_result("bp_b", 8'd24, 1'b0);
        check("bp_a_one_xfer", xfers - start, 32'd1);
        @(posedge clk); #1;

        // clr mid-group discards partial sum and the concurrent beat
        feed(18'd100, 5);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_psum  = 18'd100;
        @(posedge clk); #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_no_result", {31'd0, out_valid}, 32'd0);
        feed(18'd32, 12);
        check_result("clr_after", 8'd24, 1'b0);
        @(posedge clk); #1;

        // async reset mid-group, then a held result discarded by reset
        feed(18'd16, 7);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        feed(18'd16, 12);
        check_result("arst_after", 8'd12, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        feed(18'd16, 12);
        #2 rst = 1'b1;
        #1;
        check("arst_held_valid", {31'd0, out_valid}, 32'd0);
        check("arst_held_data",  {24'd0, out_data},  32'd0);
        @(negedge clk) rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // back-to-back: 24 beats, results at cycles 13 and 25, no stalls
        start   = xfers;
        vpat    = '0;
        rdy_all = 1'b1;
        d12     = '0;
        d24     = '0;
        for (int c = 1; c <= 24; c++) begin
            in_valid = 1'b1;
            in_psum  = 18'd16;
            if (!in_ready) rdy_all = 1'b0;
            @(posedge clk); #1;
            vpat[c-1] = out_valid;
            if (c == 12) d12 = out_data;
            if (c == 24) d24 = out_data;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_in_ready",   {31'd0, rdy_all}, 32'd1);
        check("b2b_valid_pat",  {8'd0, vpat},     32'h800800);
        check("b2b_data_13",    {24'd0, d12},     32'd12);
        check("b2b_data_25",    {24'd0, d24},     32'd12);
        check("b2b_xfers",      xfers - start,    32'd2);
        check("b2b_idle_valid", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Downstream consumer of the `vector_mult` dot-product stage.
- Takes one partial sum per beat, each being one kernel row of `TERMS` products.
- Accumulates `TERMS` rows × `CHANNELS` input channels into one output pixel, then requantizes by right shift with unsigned saturation to `DATA_WIDTH`.
- Presents the result through a single-entry valid/ready output register to the next layer stage.

Parameters:
- `DATA_WIDTH`, default 8: operand and output width.
- `PSUM_WIDTH`, default `2*DATA_WIDTH+2` (18): input partial-sum width.
- `TERMS`, default 3: kernel rows per channel, i.e. psums per channel.
- `CHANNELS`, default 4: input channels summed per output pixel.
- `ACC_WIDTH`, default `PSUM_WIDTH+4` (22): accumulator width; must hold `TERMS*CHANNELS*(2^PSUM_WIDTH-1)` without overflow for the configured sizes.
- `OUT_SHIFT`, default 4: arithmetic right shift applied to the final sum before saturation.

Ports:
- `clk`  input  1  — single clock; all state on rising edge.
- `rst`  input  1  — asynchronous, active-high reset.
- `clr`  input  1  — synchronous discard of the partial accumulation.
- `in_valid`  input  1  — `in_psum` valid.
- `in_ready`  output  1  — block accepts `in_psum` this cycle.
- `in_psum`  input  `PSUM_WIDTH`  — unsigned partial sum.
- `out_valid`  output  1  — `out_data` / `out_sat` hold a result.
- `out_ready`  input  1  — downstream accepts the result.
- `out_data`  output  `DATA_WIDTH`  — saturated, shifted result.
- `out_sat`  output  1  — result was clamped.
- `busy`  output  1  — partial accumulation in progress.

Behaviour:
- **Reset (async, `rst`=1):**
  - acc=0, term_cnt=0, ch_cnt=0.
  - out_valid=0, out_data=0, out_sat=0, busy=0.
  - in_ready=1 once rst is deasserted.
  - Reset mid-group discards the partial sum and any held result.
- **Handshake:**
  - Beat accepted iff `in_valid && in_ready`.
  - `in_ready = !out_valid || out_ready`, combinational from `out_valid`/`out_ready` only.
  - Output transfer iff `out_valid && out_ready`.
- **Counters:**
  - `term_cnt` advances 0..`TERMS-1` per accepted beat and wraps to 0.
  - On wrap, `ch_cnt` advances 0..`CHANNELS-1`.
  - Final beat = term_cnt==`TERMS-1` and ch_cnt==`CHANNELS-1`.
- **State:**
  - IDLE: both counters 0, acc=0, busy=0.
  - ACCUM: busy=1.
  - IDLE→ACCUM on the first accepted beat.
  - ACCUM→IDLE on the final beat or on `clr`.
- **Non-final accepted beat:**
  - acc ← acc + zero-extended `in_psum`.
- **Final accepted beat:**
  - sum = acc + `in_psum` (`ACC_WIDTH`).
  - s = sum >> `OUT_SHIFT`.
  - out_data ← (s > 2^`DATA_WIDTH`-1) ? all ones : s[`DATA_WIDTH`-1:0].
  - out_sat ← clamp flag.
  - out_valid ← 1; acc ← 0; counters ← 0.
  - Latency: result visible the cycle after the final beat is accepted.
- **Output register:**
  - out_valid clears on transfer unless a final beat is accepted in the same cycle; in that case the new result loads and out_valid stays 1.
  - out_data / out_sat are stable while out_valid && !out_ready.
- **`clr`:**
  - Sets acc=0 and counters=0.
  - An input beat accepted in the same cycle is discarded.
  - A held result (out_valid) is unaffected.
  - clr has priority over the accumulate/load logic for the input side only.
- **No overflow detection on acc:** `ACC_WIDTH` sizing is the integrator's responsibility; the defaults cover the full range (12 × 195075 = 2 340 900 < 2^22).
- **Back-to-back:** with out_ready held 1, one beat per cycle is sustained indefinitely with no bubbles.

Test Plan (defaults `DATA_WIDTH`=8, `TERMS`=3, `CHANNELS`=4, `OUT_SHIFT`=4):
1. **Basic result:** 12 consecutive beats, `in_psum`=16, out_ready=1 → one cycle after beat 12: out_valid=1, out_data=12 (192>>4), out_sat=0. busy=1 from beat 1 through beat 12, 0 after.
2. **Saturation:** 12 beats of `in_psum`=195075 → sum 2340900, >>4 = 146306 → out_data=255, out_sat=1.
3. **Backpressure:**
   - Group A: 12×16 with out_ready=0 → out_valid=1, out_data=12 held; in_ready=0.
   - Group B (12×32) is offered while in_ready=0 → no beat accepted, counters do not advance.
   - Raise out_ready → A transfers; B accepted; result out_data=24.
4. **`clr` mid-group:** 5 beats of 100, then clr=1 together with in_valid (beat discarded), then 12 beats of 32 → out_data=24, out_sat=0; busy=0 the cycle after clr.
5. **Async reset mid-operation:**
   - After 7 beats, pulse rst asynchronously (not clock-aligned) → immediately out_valid=0, busy=0.
   - After release, 12×16 → out_data=12.
6. **Simultaneous load/transfer:** 24 back-to-back beats of 16 with out_ready=1 → in_ready never drops. out_valid=1 at cycles 13 and 25 (beat 1 at cycle 1), out_data=12 both; exactly 2 transfers.
